// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: sole write-side master of the 31-entry register file.
// Merges never-stalling pipeline writeback with buffered long-latency results.
//
// Ports:
//   CLK, RST_X              clock, async active-low reset
//   P_VALID/P_RD/P_DATA     pipeline writeback (highest priority, never stalls)
//   LL_VALID/LL_READY       long-latency result handshake into the FIFO
//   LL_RD/LL_DATA           long-latency destination and data
//   ISSUE_VALID/ISSUE_RD    long-latency issue; marks destination pending
//   WNUM/WDATA              registered rf write port (WNUM=0 means no write)
//   BUSY                    pending-destination bitmap (bit 0 always 0)
//   LL_COUNT                FIFO occupancy
//
// Optional macro RF_WB_BYPASS_EN: an LL result arriving at an empty FIFO
// while the pipeline is not writing skips the FIFO (1-cycle LL latency).
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  P_VALID,
    input  logic [4:0]            P_RD,
    input  logic [31:0]           P_DATA,
    input  logic                  LL_VALID,
    output logic                  LL_READY,
    input  logic [4:0]            LL_RD,
    input  logic [31:0]           LL_DATA,
    input  logic                  ISSUE_VALID,
    input  logic [4:0]            ISSUE_RD,
    output logic [4:0]            WNUM,
    output logic [31:0]           WDATA,
    output logic [31:0]           BUSY,
    output logic [DEPTH_LOG2:0]   LL_COUNT
);

    localparam logic [DEPTH_LOG2:0]   FULL    = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [4:0]            fifo_rd   [DEPTH];
    logic [31:0]           fifo_data [DEPTH];
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_d;

    logic [4:0]            wnum_q;
    logic [4:0]            wnum_d;
    logic [31:0]           wdata_q;
    logic [31:0]           wdata_d;
    logic [31:0]           busy_q;
    logic [31:0]           busy_d;
    logic [31:0]           set_m;
    logic [31:0]           clr_m;

    logic                  p_wr;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  bypass;
    logic                  fifo_push;
    logic [4:0]            head_rd;
    logic [31:0]           head_data;

    assign p_wr      = P_VALID && (P_RD != 5'd0);
    assign empty     = (count == '0);
    assign LL_READY  = (count != FULL);
    assign push      = LL_VALID && LL_READY;
    assign head_rd   = fifo_rd[rptr];
    assign head_data = fifo_data[rptr];

`ifdef RF_WB_BYPASS_EN
    assign bypass    = push && empty && !p_wr;
`else
    assign bypass    = 1'b0;
`endif

    assign fifo_push = push && !bypass;
    // A zero-destination pipeline request is a no-write and lets the FIFO drain.
    assign pop       = !p_wr && !empty;

    always_comb begin
        wnum_d  = 5'd0;
        wdata_d = wdata_q;
        clr_m   = '0;
        unique case (1'b1)
            p_wr: begin
                wnum_d  = P_RD;
                wdata_d = P_DATA;
            end
            pop: begin
                wnum_d         = head_rd;
                wdata_d        = head_data;
                clr_m[head_rd] = 1'b1;
            end
            bypass: begin
                wnum_d       = LL_RD;
                wdata_d      = LL_DATA;
                clr_m[LL_RD] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        set_m = '0;
        if (ISSUE_VALID && (ISSUE_RD != 5'd0)) begin
            set_m[ISSUE_RD] = 1'b1;
        end
        // Set is applied after clear so a same-cycle issue wins; r0 never pends.
        busy_d = ((busy_q & ~clr_m) | set_m) & ~32'd1;
    end

    always_comb begin
        count_d = count;
        unique case ({fifo_push, pop})
            2'b10:   count_d = count + CNT_ONE;
            2'b01:   count_d = count - CNT_ONE;
            default: count_d = count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wnum_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
            count   <= '0;
            rptr    <= '0;
            wptr    <= '0;
        end else begin
            wnum_q  <= wnum_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            count   <= count_d;
            if (fifo_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (fifo_push) begin
            fifo_rd[wptr]   <= LL_RD;
            fifo_data[wptr] <= LL_DATA;
        end
    end

    assign WNUM     = wnum_q;
    assign WDATA    = wdata_q;
    assign BUSY     = busy_q;
    assign LL_COUNT = count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter.
// Queue-based reference model; monitor compares on every falling edge.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b1;
    logic        P_VALID = 1'b0;
    logic [4:0]  P_RD = '0;
    logic [31:0] P_DATA = '0;
    logic        LL_VALID = 1'b0;
    logic        LL_READY;
    logic [4:0]  LL_RD = '0;
    logic [31:0] LL_DATA = '0;
    logic        ISSUE_VALID = 1'b0;
    logic [4:0]  ISSUE_RD = '0;
    logic [4:0]  WNUM;
    logic [31:0] WDATA;
    logic [31:0] BUSY;
    logic [2:0]  LL_COUNT;

    always #5 CLK = ~CLK;

    rf_wb_arbiter #(.DEPTH(4), .DEPTH_LOG2(2)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .P_VALID(P_VALID), .P_RD(P_RD), .P_DATA(P_DATA),
        .LL_VALID(LL_VALID), .LL_READY(LL_READY),
        .LL_RD(LL_RD), .LL_DATA(LL_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
        .WNUM(WNUM), .WDATA(WDATA), .BUSY(BUSY), .LL_COUNT(LL_COUNT)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ll_t;

    typedef struct {
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic [2:0]  cnt;
        logic        rdy;
    } exp_t;

    ll_t         llq[$];
    exp_t        exp_q[$];
    logic [31:0] m_wdata = '0;
    logic [31:0] m_busy = '0;
    int          checks = 0;
    int          failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One clock edge of the arbiter, described as queue operations.
    function automatic exp_t model(bit pv, logic [4:0] prd, logic [31:0] pd,
                                   bit lv, logic [4:0] lrd, logic [31:0] ld,
                                   bit iv, logic [4:0] ird);
        exp_t e;
        ll_t  h;
        bit   p_wr;
        bit   push;
        bit   byp;
        p_wr = pv && (prd != 0);
        push = lv && (llq.size() < DEPTH);
        byp  = 1'b0;
`ifdef RF_WB_BYPASS_EN
        byp  = push && (llq.size() == 0) && !p_wr;
`endif
        e.wnum = 5'd0;
        if (p_wr) begin
            e.wnum  = prd;
            m_wdata = pd;
        end else if (llq.size() != 0) begin
            h = llq.pop_front();
            e.wnum = h.rd;
            m_wdata = h.data;
            m_busy[h.rd] = 1'b0;
        end else if (byp) begin
            e.wnum = lrd;
            m_wdata = ld;
            m_busy[lrd] = 1'b0;
        end
        if (push && !byp) begin
            h.rd = lrd;
            h.data = ld;
            llq.push_back(h);
        end
        if (iv && ird != 0) m_busy[ird] = 1'b1;
        m_busy[0] = 1'b0;
        e.wdata = m_wdata;
        e.busy  = m_busy;
        e.cnt   = 3'(llq.size());
        e.rdy   = llq.size() < DEPTH;
        return e;
    endfunction

    task automatic cyc(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ird);
        exp_t e;
        P_VALID = pv; P_RD = prd; P_DATA = pd;
        LL_VALID = lv; LL_RD = lrd; LL_DATA = ld;
        ISSUE_VALID = iv; ISSUE_RD = ird;
        e = model(pv, prd, pd, lv, lrd, ld, iv, ird);
        @(posedge CLK);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        P_VALID = 0; LL_VALID = 0; ISSUE_VALID = 0;
        RST_X = 1'b0;
        exp_q.delete();
        llq.delete();
        m_busy = '0;
        m_wdata = '0;
        #1;
        chk("rst_wnum", 32'(WNUM), 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_count", 32'(LL_COUNT), 0);
        chk("rst_wdata", WDATA, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_X = 1'b1;
        #1;
        chk("rst_ready", 32'(LL_READY), 1);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST_X && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wnum", 32'(WNUM), 32'(e.wnum));
            chk("wdata", WDATA, e.wdata);
            chk("busy", BUSY, e.busy);
            chk("count", 32'(LL_COUNT), 32'(e.cnt));
            chk("ready", 32'(LL_READY), 32'(e.rdy));
        end
    end

    initial begin
        int k;
        int n;
        bit acc;
        #1;
        do_reset();
        repeat (6) idle();

        // Single pipeline write.
        cyc(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0);
        chk("p_wnum", 32'(WNUM), 5);
        chk("p_wdata", WDATA, 32'h1234_5678);
        idle();
        chk("p_wnum_after", 32'(WNUM), 0);

        // Issue r7, then its long-latency result.
        cyc(0, 0, 0, 0, 0, 0, 1, 7);
        chk("busy7_set", 32'(BUSY[7]), 1);
        cyc(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 0, 0);
`ifdef RF_WB_BYPASS_EN
        chk("ll_wnum_byp", 32'(WNUM), 7);
        chk("busy7_clr", 32'(BUSY[7]), 0);
        idle();
`else
        chk("ll_wnum_wait", 32'(WNUM), 0);
        chk("busy7_hold", 32'(BUSY[7]), 1);
        idle();
        chk("ll_wnum", 32'(WNUM), 7);
        chk("busy7_clr", 32'(BUSY[7]), 0);
`endif
        repeat (2) idle();

        // Fill while the pipeline writes every cycle: only DEPTH fit.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 5'(10 + i));
        for (int i = 0; i < 5; i++)
            cyc(1, 5'(20 + i), $urandom, 1, 5'(10 + i), $urandom, 0, 0);
        chk("full_count", 32'(LL_COUNT), 4);
        chk("full_ready", 32'(LL_READY), 0);

        // Offer at full while draining; hold on refusal, wrap pointers 3+ times.
        k = 0;
        for (int c = 0; c < 16; c++) begin
            acc = (llq.size() < DEPTH);
            cyc(0, 0, 0, 1, 5'(1 + (k % 31)), 32'hA000_0000 + 32'(k), 0, 0);
            if (c == 0) chk("refused_count", 32'(LL_COUNT), 3);
            if (acc) k++;
        end
        repeat (6) idle();

        // Same-cycle issue and pop of r3, then reset mid-drain.
        cyc(0, 0, 0, 0, 0, 0, 1, 3);
        cyc(1, 1, 32'h11, 1, 3, 32'h33, 0, 0);
        cyc(1, 2, 32'h22, 1, 9, 32'h99, 1, 9);
        cyc(1, 4, 32'h44, 1, 12, 32'hCC, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 3);
        chk("busy3_setwins", 32'(BUSY[3]), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain_wnum9", 32'(WNUM), 9);
        @(negedge CLK);
        #1;
        do_reset();
        repeat (3) idle();

        // Randomized traffic.
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc(($urandom_range(0, 99) < 45), 5'($urandom), $urandom,
                ($urandom_range(0, 99) < 55), 5'($urandom), $urandom,
                ($urandom_range(0, 99) < 30), 5'($urandom));
            n++;
        end
        repeat (8) idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-side master for the 31-entry register file; sole driver of its WNUM/WDATA write port.
- Merges two writeback sources: the in-order pipeline writeback, which never stalls, and long-latency units (load miss, divider), which are buffered in a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on RAW hazards against outstanding long-latency results.
- Sits between the WB stage / long-latency units and rf.

Parameters:
DEPTH, 4, long-latency FIFO entries (power of 2, >=2)
DEPTH_LOG2, 2, log2(DEPTH); pointer width

Ports:
CLK  in  1  clock; all state updates on posedge
RST_X  in  1  asynchronous active-low reset
P_VALID  in  1  pipeline writeback request this cycle
P_RD  in  5  pipeline destination register
P_DATA  in  32  pipeline writeback data
LL_VALID  in  1  long-latency result offered
LL_READY  out  1  FIFO can accept; push = LL_VALID & LL_READY
LL_RD  in  5  long-latency destination register
LL_DATA  in  32  long-latency result data
ISSUE_VALID  in  1  long-latency op issued (marks destination pending)
ISSUE_RD  in  5  destination of issued op
WNUM  out  5  to rf write number; 0 = no write
WDATA  out  32  to rf write data
BUSY  out  32  scoreboard bitmap; bit i = reg i has outstanding LL result
LL_COUNT  out  DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset (RST_X low, async): WNUM=0, WDATA=0, BUSY=0, FIFO empty (pointers and count 0), LL_COUNT=0, LL_READY=1 once reset is released.
- WNUM/WDATA are registered; rf samples them on the following posedge.
- Each cycle, exactly one selection is made, by priority:
  - Pipeline: if P_VALID & P_RD!=0, the next WNUM/WDATA = P_RD/P_DATA. Pipeline latency: accept cycle n -> on port during n+1.
  - FIFO head: else if the FIFO is non-empty, pop the head and set the next WNUM/WDATA = head rd/data.
  - Idle: else the next WNUM=0 and WDATA holds its previous value.
- P_VALID with P_RD=0 is a no-write. It does not block the FIFO pop.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read/write pointers wrapping modulo DEPTH; count register from 0 to DEPTH.
  - LL_READY = (count != DEPTH), computed from the registered count only.
  - Pop and push in the same cycle at full: the push is refused because LL_READY=0 that cycle.
  - Push and pop together when non-full: count unchanged, both pointers advance.
  - A pushed entry with LL_RD=0 is stored and later popped as a no-write (WNUM=0). It still consumes a slot.
- LL latency, without bypass: minimum 2 cycles from push to WNUM (push n, pop n+1, port n+2).
- Scoreboard:
  - ISSUE_VALID & ISSUE_RD!=0 sets BUSY[ISSUE_RD] on the next edge.
  - A FIFO pop clears BUSY[head rd] on the same edge that loads WNUM.
  - Same register set and cleared in one cycle: set wins.
  - BUSY[0] is constant 0.
- BUSY is not cleared by pipeline writes. WAW ordering between pipeline and LL writes to the same register is the issuer's responsibility.
- Reset mid-operation: all FIFO contents and pending bits are discarded immediately; WNUM=0 asynchronously.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined:
  - If the FIFO is empty, the pipeline is not writing (no P_VALID with P_RD!=0), and an LL push occurs, the LL result goes straight to WNUM/WDATA the next cycle instead of entering the FIFO.
  - Count is unchanged and BUSY[LL_RD] is cleared on that edge.
  - LL latency becomes 1 cycle.
- When undefined: all LL results pass through the FIFO, giving 2-cycle minimum latency.

Test Plan:
- Reset, then release with no requests -> WNUM=0, BUSY=0, LL_READY=1, LL_COUNT=0 indefinitely.
- P_VALID with P_RD=5, P_DATA=0x1234_5678 for one cycle -> the next cycle WNUM=5, WDATA=0x12345678; the cycle after, WNUM=0.
- ISSUE_RD=7, then LL push rd=7 data=0xDEAD_BEEF with the pipeline idle -> BUSY[7]=1 until the pop. WNUM=7 appears 2 cycles after the push (1 with RF_WB_BYPASS_EN), and BUSY[7]=0 on that same cycle.
- Pipeline writing every cycle while 5 LL pushes are offered -> exactly 4 accepted, LL_READY=0 and LL_COUNT=4. When the pipeline stops, WNUM shows the 4 entries in push order on consecutive cycles.
- At LL_COUNT=4, assert LL_VALID while a pop occurs -> the push is refused that cycle and accepted the next, and the pointers wrap correctly (verified over 3 full wrap cycles).
- Same-cycle ISSUE_RD=3 and pop of rd=3 -> BUSY[3] stays 1. Then pull RST_X low mid-drain -> WNUM=0 and BUSY=0 immediately, LL_COUNT=0.
